// File: rtl/register_file_mp.sv
// Multi-ported register file: one write port, two registered read ports with
// write-to-read bypass, optional hardwired-zero entry 0, and a hardware sweep-clear.
module register_file_mp #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic [AW-1:0]    write_sel,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    read_sel_a,
    input  logic [AW-1:0]    read_sel_b,
    output logic [WIDTH-1:0] data_out_a,
    output logic [WIDTH-1:0] data_out_b,
    input  logic             clear_req,
    output logic             busy
);

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic [AW-1:0]    index_reg, index_next;
    logic             sweep_active;
    logic             write_ok;
    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [AW-1:0]    rd_sel  [2];
    logic [WIDTH-1:0] rd_q    [2];

    // An address is "live" if it maps to a real, writable entry.
    function automatic logic addr_live(input logic [AW-1:0] sel);
        return ({1'b0, sel} < DEPTH_W) && !((ZERO_REG != 0) && (sel == '0));
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            index_reg <= '0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        case (state_reg)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    index_next = '0;
                end
            end
            CLEAR: begin
                index_next = index_reg + 1'b1;
                if (index_reg == LAST_IDX) begin
                    state_next = IDLE;
                    index_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                index_next = '0;
            end
        endcase
    end

    always_comb begin
        sweep_active = (state_reg == CLEAR);
        busy         = sweep_active;
    end

    assign write_ok = write_en && !sweep_active && addr_live(write_sel);

    // Sweep and write never coincide on an entry: writes are refused while sweeping.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] value_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                value_reg <= '0;
            end else if (sweep_active && (index_reg == AW'(gi))) begin
                value_reg <= '0;
            end else if (write_ok && (write_sel == AW'(gi))) begin
                value_reg <= data_in;
            end
        end

        assign entry_q[gi] = value_reg;
    end

    assign rd_sel[0] = read_sel_a;
    assign rd_sel[1] = read_sel_b;

    // Each read port sees the value the entry holds after this edge.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [WIDTH-1:0] q_reg;
        logic [WIDTH-1:0] q_next;

        always_comb begin
            q_next = entry_q[rd_sel[gi]];
            if (!addr_live(rd_sel[gi])) begin
                q_next = '0;
            end else if (sweep_active && (rd_sel[gi] == index_reg)) begin
                q_next = '0;
            end else if (write_ok && (rd_sel[gi] == write_sel)) begin
                q_next = data_in;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                q_reg <= '0;
            end else begin
                q_reg <= q_next;
            end
        end

        assign rd_q[gi] = q_reg;
    end

    assign data_out_a = rd_q[0];
    assign data_out_b = rd_q[1];

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: default, ZERO_REG=1 and DEPTH=6 instances
// share stimulus; each scenario task checks the instance it targets.
module tb_register_file_mp;

    logic       clk;
    logic       reset;
    logic       write_en;
    logic [2:0] write_sel;
    logic [7:0] data_in;
    logic [2:0] read_sel_a;
    logic [2:0] read_sel_b;
    logic       clear_req;

    logic [7:0] oa_m, ob_m, oa_z, ob_z, oa_6, ob_6;
    logic       busy_m, busy_z, busy_6;

    int checks;
    int failures;

    register_file_mp #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) dut_m (
        .clk(clk), .reset(reset), .write_en(write_en), .write_sel(write_sel),
        .data_in(data_in), .read_sel_a(read_sel_a), .read_sel_b(read_sel_b),
        .data_out_a(oa_m), .data_out_b(ob_m), .clear_req(clear_req), .busy(busy_m)
    );

    register_file_mp #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .write_en(write_en), .write_sel(write_sel),
        .data_in(data_in), .read_sel_a(read_sel_a), .read_sel_b(read_sel_b),
        .data_out_a(oa_z), .data_out_b(ob_z), .clear_req(clear_req), .busy(busy_z)
    );

    register_file_mp #(.WIDTH(8), .DEPTH(6), .ZERO_REG(0)) dut_6 (
        .clk(clk), .reset(reset), .write_en(write_en), .write_sel(write_sel),
        .data_in(data_in), .read_sel_a(read_sel_a), .read_sel_b(read_sel_b),
        .data_out_a(oa_6), .data_out_b(ob_6), .clear_req(clear_req), .busy(busy_6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] ws, input logic [7:0] d,
                         input logic [2:0] ra, input logic [2:0] rb, input logic cr);
        write_en   = we;
        write_sel  = ws;
        data_in    = d;
        read_sel_a = ra;
        read_sel_b = rb;
        clear_req  = cr;
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        write_en = 1'b1; write_sel = 3'd3; data_in = 8'hFF;
        read_sel_a = 3'd3; read_sel_b = 3'd3; clear_req = 1'b1;
        repeat (2) cycle();
        checks++; if (oa_m !== 8'h00) begin failures++; $display("FAIL reset_oa_m got=%h exp=00", oa_m); end
        checks++; if (ob_m !== 8'h00) begin failures++; $display("FAIL reset_ob_m got=%h exp=00", ob_m); end
        checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL reset_busy_m got=%b exp=0", busy_m); end
        checks++; if (busy_z !== 1'b0) begin failures++; $display("FAIL reset_busy_z got=%b exp=0", busy_z); end
        checks++; if (busy_6 !== 1'b0) begin failures++; $display("FAIL reset_busy_6 got=%b exp=0", busy_6); end
        reset = 1'b1; write_en = 1'b0; clear_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 1'b0);
            checks++; if (oa_m !== 8'h00) begin failures++; $display("FAIL reset_entry_a[%0d] got=%h exp=00", i, oa_m); end
            checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL reset_no_sweep[%0d] got=%b exp=0", i, busy_m); end
        end
        $display("reset: entries read back after release");
    endtask

    task automatic test_basic();
        drive(1'b1, 3'd3, 8'h5A, 3'd0, 3'd0, 1'b0);
        checks++; if (oa_m !== 8'h00) begin failures++; $display("FAIL basic_entry0 got=%h exp=00", oa_m); end
        drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 1'b0);
        checks++; if (oa_m !== 8'h5A) begin failures++; $display("FAIL basic_read_a got=%h exp=5a", oa_m); end
        checks++; if (ob_m !== 8'h5A) begin failures++; $display("FAIL basic_read_b got=%h exp=5a", ob_m); end
        drive(1'b1, 3'd1, 8'h21, 3'd0, 3'd0, 1'b0);
        drive(1'b1, 3'd6, 8'h96, 3'd0, 3'd0, 1'b0);
        drive(1'b0, 3'd0, 8'h00, 3'd1, 3'd6, 1'b0);
        checks++; if (oa_m !== 8'h21) begin failures++; $display("FAIL basic_e1 got=%h exp=21", oa_m); end
        checks++; if (ob_m !== 8'h96) begin failures++; $display("FAIL basic_e6 got=%h exp=96", ob_m); end
        drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd3, 1'b0);
        checks++; if (oa_m !== 8'h96) begin failures++; $display("FAIL basic_e6_a got=%h exp=96", oa_m); end
        checks++; if (ob_m !== 8'h5A) begin failures++; $display("FAIL basic_e3_b got=%h exp=5a", ob_m); end
        $display("basic: wrote 3/1/6, read both ports");
    endtask

    task automatic test_bypass();
        drive(1'b1, 3'd2, 8'hC3, 3'd2, 3'd2, 1'b0);
        checks++; if (oa_m !== 8'hC3) begin failures++; $display("FAIL bypass_a got=%h exp=c3", oa_m); end
        checks++; if (ob_m !== 8'hC3) begin failures++; $display("FAIL bypass_b got=%h exp=c3", ob_m); end
        drive(1'b1, 3'd5, 8'h77, 3'd5, 3'd3, 1'b0);
        checks++; if (oa_m !== 8'h77) begin failures++; $display("FAIL bypass_a5 got=%h exp=77", oa_m); end
        checks++; if (ob_m !== 8'h5A) begin failures++; $display("FAIL nobypass_b3 got=%h exp=5a", ob_m); end
        drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd5, 1'b0);
        checks++; if (oa_m !== 8'hC3) begin failures++; $display("FAIL bypass_held2 got=%h exp=c3", oa_m); end
        checks++; if (ob_m !== 8'h77) begin failures++; $display("FAIL bypass_held5 got=%h exp=77", ob_m); end
        $display("bypass: same-edge write/read on 2 and 5");
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 1'b0);
        checks++; if (oa_z !== 8'h00) begin failures++; $display("FAIL zero_bypass_a got=%h exp=00", oa_z); end
        checks++; if (ob_z !== 8'h00) begin failures++; $display("FAIL zero_bypass_b got=%h exp=00", ob_z); end
        checks++; if (oa_m !== 8'hFF) begin failures++; $display("FAIL nonzero_bypass got=%h exp=ff", oa_m); end
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd3, 1'b0);
        checks++; if (oa_z !== 8'h00) begin failures++; $display("FAIL zero_read got=%h exp=00", oa_z); end
        checks++; if (ob_z !== 8'h5A) begin failures++; $display("FAIL zero_inst_e3 got=%h exp=5a", ob_z); end
        checks++; if (oa_m !== 8'hFF) begin failures++; $display("FAIL nonzero_e0 got=%h exp=ff", oa_m); end
        $display("zero_reg: write ff to entry 0");
    endtask

    task automatic test_depth6();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        drive(1'b1, 3'd7, 8'h99, 3'd7, 3'd7, 1'b0);
        checks++; if (oa_6 !== 8'h00) begin failures++; $display("FAIL d6_oob_bypass_a got=%h exp=00", oa_6); end
        checks++; if (ob_6 !== 8'h00) begin failures++; $display("FAIL d6_oob_bypass_b got=%h exp=00", ob_6); end
        checks++; if (oa_m !== 8'h99) begin failures++; $display("FAIL d8_e7_bypass got=%h exp=99", oa_m); end
        drive(1'b1, 3'd6, 8'h66, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 8'h00, 3'(i), 3'(i), 1'b0);
            checks++; if (oa_6 !== 8'h00) begin failures++; $display("FAIL d6_entry[%0d] got=%h exp=00", i, oa_6); end
        end
        drive(1'b1, 3'd5, 8'h3C, 3'd5, 3'd0, 1'b0);
        checks++; if (oa_6 !== 8'h3C) begin failures++; $display("FAIL d6_bypass5 got=%h exp=3c", oa_6); end
        drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd7, 1'b0);
        checks++; if (oa_6 !== 8'h3C) begin failures++; $display("FAIL d6_e5 got=%h exp=3c", oa_6); end
        checks++; if (ob_6 !== 8'h00) begin failures++; $display("FAIL d6_e7 got=%h exp=00", ob_6); end
        $display("depth6: out-of-range writes/reads");
    endtask

    task automatic test_clear();
        logic [7:0] exp_b;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 8'((i + 1) * 17), 3'd0, 3'd0, 1'b0);
        end
        drive(1'b1, 3'd4, 8'hEE, 3'd4, 3'd4, 1'b1);
        checks++; if (oa_m !== 8'hEE) begin failures++; $display("FAIL clear_start_write got=%h exp=ee", oa_m); end
        checks++; if (busy_m !== 1'b1) begin failures++; $display("FAIL clear_start_busy got=%b exp=1", busy_m); end
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'd0, 8'hAB, 3'(k), 3'd7, (k == 3));
            exp_b = (k < 7) ? 8'h88 : 8'h00;
            checks++; if (oa_m !== 8'h00) begin failures++; $display("FAIL clear_read_swept[%0d] got=%h exp=00", k, oa_m); end
            checks++; if (ob_m !== exp_b) begin failures++; $display("FAIL clear_read_e7[%0d] got=%h exp=%h", k, ob_m, exp_b); end
            checks++; if (busy_m !== logic'(k < 7)) begin failures++; $display("FAIL clear_busy[%0d] got=%b exp=%b", k, busy_m, logic'(k < 7)); end
        end
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
        checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL clear_no_restart got=%b exp=0", busy_m); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 1'b0);
            checks++; if (oa_m !== 8'h00) begin failures++; $display("FAIL clear_after_a[%0d] got=%h exp=00", i, oa_m); end
            checks++; if (ob_m !== 8'h00) begin failures++; $display("FAIL clear_after_b[%0d] got=%h exp=00", 7 - i, ob_m); end
        end
        drive(1'b1, 3'd1, 8'h42, 3'd0, 3'd0, 1'b0);
        drive(1'b0, 3'd0, 8'h00, 3'd1, 3'd0, 1'b0);
        checks++; if (oa_m !== 8'h42) begin failures++; $display("FAIL clear_then_write got=%h exp=42", oa_m); end
        $display("clear: 8-cycle sweep with dropped writes");
    endtask

    task automatic test_reset_mid_sweep();
        drive(1'b1, 3'd6, 8'h66, 3'd0, 3'd0, 1'b0);
        drive(1'b1, 3'd5, 8'h55, 3'd0, 3'd0, 1'b0);
        drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd5, 1'b1);
        drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd5, 1'b0);
        drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd5, 1'b0);
        checks++; if (busy_m !== 1'b1) begin failures++; $display("FAIL midsweep_busy got=%b exp=1", busy_m); end
        checks++; if (oa_m !== 8'h66) begin failures++; $display("FAIL midsweep_e6 got=%h exp=66", oa_m); end
        checks++; if (ob_m !== 8'h55) begin failures++; $display("FAIL midsweep_e5 got=%h exp=55", ob_m); end
        reset = 1'b0;
        #1;
        checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL async_busy got=%b exp=0", busy_m); end
        checks++; if (oa_m !== 8'h00) begin failures++; $display("FAIL async_oa got=%h exp=00", oa_m); end
        checks++; if (ob_m !== 8'h00) begin failures++; $display("FAIL async_ob got=%h exp=00", ob_m); end
        write_en = 1'b1; write_sel = 3'd7; data_in = 8'h99; clear_req = 1'b1;
        repeat (2) cycle();
        checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL held_reset_busy got=%b exp=0", busy_m); end
        reset = 1'b1; write_en = 1'b0; clear_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 8'h00, 3'(i), 3'(i), 1'b0);
            checks++; if (oa_m !== 8'h00) begin failures++; $display("FAIL postreset_e[%0d] got=%h exp=00", i, oa_m); end
        end
        checks++; if (busy_m !== 1'b0) begin failures++; $display("FAIL postreset_busy got=%b exp=0", busy_m); end
        drive(1'b1, 3'd7, 8'h42, 3'd0, 3'd0, 1'b0);
        drive(1'b0, 3'd0, 8'h00, 3'd7, 3'd7, 1'b0);
        checks++; if (oa_m !== 8'h42) begin failures++; $display("FAIL postreset_write_a got=%h exp=42", oa_m); end
        checks++; if (ob_m !== 8'h42) begin failures++; $display("FAIL postreset_write_b got=%h exp=42", ob_m); end
        $display("reset_mid_sweep: abort after 3 sweep edges");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_bypass();
        test_zero_reg();
        test_depth6();
        test_clear();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
